// File: rtl/spi_cfg_slave_if.sv
// SPI pins plus register-space strobes for the SNN config responder.
// The slave side is the responder; the master side is the host and register file.
interface spi_cfg_slave_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
);
  logic              SCK;
  logic              CS_N;
  logic              MOSI;
  logic              MISO;
  logic              WR_EN;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [DATA_W-1:0] WR_DATA;
  logic              RD_REQ;
  logic [ADDR_W-1:0] RD_ADDR;
  logic [DATA_W-1:0] RD_DATA;
  logic              RD_ACK;
  logic              RD_ERR;

  modport slave (
    input  SCK, CS_N, MOSI, RD_DATA, RD_ACK,
    output MISO, WR_EN, WR_ADDR, WR_DATA,
    output RD_REQ, RD_ADDR, RD_ERR
  );

  modport master (
    output SCK, CS_N, MOSI, RD_DATA, RD_ACK,
    input  MISO, WR_EN, WR_ADDR, WR_DATA,
    input  RD_REQ, RD_ADDR, RD_ERR
  );
endinterface

// File: rtl/spi_cfg_slave.sv
// Oversampled SPI mode-0 config slave: [CMD|ADDR|DATA] frames
// decoded into single-cycle write strobes or read requests.
module spi_cfg_slave #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16,
  parameter int SYNC_W = 2
) (
  input logic            CLK,
  input logic            RST,
  spi_cfg_slave_if.slave bus
);
  localparam int HDR_W   = 2 + ADDR_W;
  localparam int FRAME_W = HDR_W + DATA_W;
  localparam int SH_W    = (HDR_W > DATA_W) ? HDR_W : DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_W - 1);
  localparam logic [CNT_W-1:0] FRM_LAST = CNT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {
    IDLE, HDR, WDATA, RDATA, SKIP, DONE
  } state_t;

  state_t            state_q;
  logic [SYNC_W-1:0] sck_s_q, cs_s_q, mosi_s_q;
  logic              sck_prev_q, cs_prev_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SH_W-2:0]   sh_q;
  logic [SH_W-1:0]   sh_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] tx_q, tx_src;
  logic              ack_q, fell_q, bad_q;
  logic              miso_q, wr_en_q, rd_req_q, rd_err_q;
  logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic sck, cs, mosi;
  logic sck_rise, sck_fall, cs_fall, cs_rise, bit_rx;

  assign sck      = sck_s_q[SYNC_W-1];
  assign cs       = cs_s_q[SYNC_W-1];
  assign mosi     = mosi_s_q[SYNC_W-1];
  assign sck_rise = sck & ~sck_prev_q;
  assign sck_fall = ~sck & sck_prev_q;
  assign cs_fall  = ~cs & cs_prev_q;
  assign cs_rise  = cs & ~cs_prev_q;
  // a bit arriving with the deselecting CS edge still counts
  assign bit_rx   = sck_rise & (~cs | cs_rise);
  assign sh_d     = {sh_q, mosi};
  assign tx_src   = ack_q ? tx_q : bus.RD_DATA;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      sck_s_q    <= '0;
      cs_s_q     <= '0;
      mosi_s_q   <= '0;
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b0;
      cnt_q      <= '0;
      sh_q       <= '0;
      addr_q     <= '0;
      tx_q       <= '0;
      ack_q      <= 1'b0;
      fell_q     <= 1'b0;
      bad_q      <= 1'b0;
      miso_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      sck_s_q    <= {sck_s_q[SYNC_W-2:0], bus.SCK};
      cs_s_q     <= {cs_s_q[SYNC_W-2:0], bus.CS_N};
      mosi_s_q   <= {mosi_s_q[SYNC_W-2:0], bus.MOSI};
      sck_prev_q <= sck;
      cs_prev_q  <= cs;
      wr_en_q    <= 1'b0;
      rd_req_q   <= 1'b0;
      unique case (state_q)
        IDLE: if (cs_fall) state_q <= HDR;
        HDR: if (bit_rx) begin
          sh_q  <= sh_d[SH_W-2:0];
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == HDR_LAST) begin
            addr_q <= sh_d[ADDR_W-1:0];
            case (sh_d[HDR_W-1 -: 2])
              2'b01: state_q <= WDATA;
              2'b10: begin
                rd_req_q  <= 1'b1;
                rd_addr_q <= sh_d[ADDR_W-1:0];
                state_q   <= RDATA;
              end
              default: state_q <= SKIP;
            endcase
          end
        end
        WDATA: if (bit_rx) begin
          sh_q  <= sh_d[SH_W-2:0];
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == FRM_LAST) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q;
            wr_data_q <= sh_d[DATA_W-1:0];
            state_q   <= DONE;
          end
        end
        RDATA: begin
          if (bus.RD_ACK && !fell_q && !ack_q) begin
            tx_q  <= bus.RD_DATA;
            ack_q <= 1'b1;
          end
          if (sck_fall && !cs) begin
            fell_q <= 1'b1;
            if (!fell_q && !(ack_q || bus.RD_ACK)) begin
              bad_q    <= 1'b1;
              rd_err_q <= 1'b1;
              miso_q   <= 1'b0;
            end else begin
              miso_q <= bad_q ? 1'b0 : tx_src[DATA_W-1];
              tx_q   <= {tx_src[DATA_W-2:0], 1'b0};
            end
          end
          if (bit_rx) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == FRM_LAST) begin
              miso_q  <= 1'b0;
              state_q <= DONE;
            end
          end
        end
        SKIP, DONE: ;
      endcase
      // deselect aborts the frame; a strobe issued this cycle survives
      if (state_q != IDLE && cs) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        sh_q    <= '0;
        tx_q    <= '0;
        ack_q   <= 1'b0;
        fell_q  <= 1'b0;
        bad_q   <= 1'b0;
        miso_q  <= 1'b0;
      end
    end
  end

  assign bus.MISO    = miso_q;
  assign bus.WR_EN   = wr_en_q;
  assign bus.WR_ADDR = wr_addr_q;
  assign bus.WR_DATA = wr_data_q;
  assign bus.RD_REQ  = rd_req_q;
  assign bus.RD_ADDR = rd_addr_q;
  assign bus.RD_ERR  = rd_err_q;
endmodule

// File: tb/tb_spi_cfg_slave.sv
// Host-side SPI master, register-file responder and scoreboard
// for the spi_cfg_slave config responder.
module tb_spi_cfg_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_cfg_slave_if #(.ADDR_W(14), .DATA_W(16)) bus ();
  spi_cfg_slave #(.ADDR_W(14), .DATA_W(16), .SYNC_W(2)) dut (
    .CLK(clk), .RST(rst), .bus(bus)
  );

  int nchk = 0;
  int nerr = 0;
  int spur_wr = 0;
  int spur_rd = 0;
  int n_wr_push = 0;
  int n_wr_seen = 0;

  logic [29:0] exp_wr[$];
  logic [13:0] exp_ra[$];
  logic [15:0] exp_rd[$];

  bit          rsp_en = 1'b1;
  int          rsp_dly = 3;
  logic [15:0] rsp_data = '0;
  logic        wr_prev = 1'b0;
  logic        rq_prev = 1'b0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_xfer(input logic [31:0] w, input int nbits,
                          input int half, input bit keep_cs,
                          input bit fast_end, output logic [31:0] rx);
    logic [31:0] sh;
    sh = w;
    rx = '0;
    bus.CS_N = 1'b0;
    wait_clk(half);
    for (int b = 0; b < nbits; b++) begin
      bus.MOSI = sh[31];
      sh = {sh[30:0], 1'b0};
      wait_clk(half);
      bus.SCK = 1'b1;
      rx = {rx[30:0], bus.MISO};
      if (fast_end && b == nbits - 1) bus.CS_N = 1'b1;
      wait_clk(half);
      bus.SCK = 1'b0;
    end
    bus.MOSI = 1'b0;
    if (!keep_cs) begin
      wait_clk(half);
      bus.CS_N = 1'b1;
      wait_clk(4 * half);
    end
  endtask

  task automatic wr_frame(input logic [13:0] a, input logic [15:0] d,
                          input int nbits, input int half,
                          input bit fast_end, input bit lands);
    logic [31:0] rx;
    if (lands) begin
      exp_wr.push_back({a, d});
      n_wr_push++;
    end
    spi_xfer({2'b01, a, d}, nbits, half, 1'b0, fast_end, rx);
    check("wr_miso_zero", rx, 0);
  endtask

  task automatic rd_frame(input logic [13:0] a, input logic [15:0] d,
                          input bit en, input int dly, input bit ok);
    logic [31:0] rx;
    rsp_en = en;
    rsp_dly = dly;
    rsp_data = d;
    exp_ra.push_back(a);
    exp_rd.push_back(ok ? d : 16'h0000);
    spi_xfer({2'b10, a, 16'h0000}, 32, 6, 1'b0, 1'b0, rx);
    check("rd_miso", rx, {16'h0000, exp_rd.pop_front()});
  endtask

  // register-file side: acknowledge each read after rsp_dly clocks
  initial begin
    bus.RD_ACK = 1'b0;
    bus.RD_DATA = '0;
    forever begin
      @(negedge clk);
      if (bus.RD_REQ && rsp_en && !rst) begin
        repeat (rsp_dly - 1) @(negedge clk);
        bus.RD_ACK = 1'b1;
        bus.RD_DATA = rsp_data;
        @(negedge clk);
        bus.RD_ACK = 1'b0;
        bus.RD_DATA = '0;
      end
    end
  end

  always @(negedge clk) begin
    logic [29:0] e;
    if (!rst) begin
      if (bus.WR_EN) begin
        n_wr_seen++;
        check("wr_rd_excl", bus.RD_REQ, 0);
        check("wr_width", wr_prev, 0);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          check("wr_addr", bus.WR_ADDR, e[29:16]);
          check("wr_data", bus.WR_DATA, e[15:0]);
        end else spur_wr++;
      end
      if (bus.RD_REQ) begin
        check("rd_width", rq_prev, 0);
        if (exp_ra.size() != 0) check("rd_addr", bus.RD_ADDR, exp_ra.pop_front());
        else spur_rd++;
      end
    end
    wr_prev <= bus.WR_EN;
    rq_prev <= bus.RD_REQ;
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_miso"}, bus.MISO, 0);
    check({tag, "_wr_en"}, bus.WR_EN, 0);
    check({tag, "_wr_addr"}, bus.WR_ADDR, 0);
    check({tag, "_wr_data"}, bus.WR_DATA, 0);
    check({tag, "_rd_req"}, bus.RD_REQ, 0);
    check({tag, "_rd_addr"}, bus.RD_ADDR, 0);
    check({tag, "_rd_err"}, bus.RD_ERR, 0);
  endtask

  initial begin
    logic [31:0] rx;
    bus.SCK = 1'b0;
    bus.CS_N = 1'b1;
    bus.MOSI = 1'b0;
    rst = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(1);
    check_reset_vals("reset");
    wait_clk(8);

    // T1 basic write
    wr_frame(14'h0123, 16'hBEEF, 32, 6, 1'b0, 1'b1);
    wait_clk(2);
    check("t1_wr_count", n_wr_seen, 1);

    // T2 read answered 3 clocks after request
    rd_frame(14'h0040, 16'hA55A, 1'b1, 3, 1'b1);
    check("t2_rd_err", bus.RD_ERR, 0);

    // T3 read never answered, then late answer, then good read
    rd_frame(14'h0041, 16'hFFFF, 1'b0, 3, 1'b0);
    check("t3_rd_err_set", bus.RD_ERR, 1);
    rd_frame(14'h0042, 16'hFFFF, 1'b1, 20, 1'b0);
    rd_frame(14'h0043, 16'h1234, 1'b1, 2, 1'b1);
    check("t3_rd_err_sticky", bus.RD_ERR, 1);

    // T4 aborted write then full write
    wr_frame(14'h0777, 16'h7777, 20, 6, 1'b0, 1'b0);
    wr_frame(14'h0001, 16'h0002, 32, 6, 1'b0, 1'b1);

    // deselect coincident with the final SCK rise still writes
    wr_frame(14'h2AAA, 16'h5555, 32, 6, 1'b1, 1'b1);

    // T5 nop with extra clocks, write with extra clocks, neuron sweep
    spi_xfer({2'b00, 14'h0100, 16'hFFFF}, 72, 6, 1'b0, 1'b0, rx);
    check("t5_nop_miso", rx, 0);
    spi_xfer({2'b11, 14'h0200, 16'hFFFF}, 32, 6, 1'b0, 1'b0, rx);
    check("t5_nop11_miso", rx, 0);
    wr_frame(14'h3FFF, 16'hC3C3, 72, 6, 1'b0, 1'b1);
    for (int i = 0; i < 64; i++)
      wr_frame(14'(i * 4), 16'(i * 257) ^ 16'h5A5A, 32, 5, 1'b0, 1'b1);
    wait_clk(2);
    check("t5_wr_count", n_wr_seen, n_wr_push);
    check("t5_rd_err_sticky", bus.RD_ERR, 1);

    // T6 reset during read data phase
    rsp_en = 1'b1;
    rsp_dly = 3;
    rsp_data = 16'hFFFF;
    exp_ra.push_back(14'h0050);
    spi_xfer({2'b10, 14'h0050, 16'h0000}, 24, 6, 1'b1, 1'b0, rx);
    check("t6_pre_rd_addr", bus.RD_ADDR, 14'h0050);
    rst = 1'b1;
    wait_clk(1);
    check_reset_vals("t6_rst");
    rst = 1'b0;
    wait_clk(6);
    bus.CS_N = 1'b1;
    wait_clk(24);
    check_reset_vals("t6_idle");
    rd_frame(14'h0060, 16'h0F0F, 1'b1, 3, 1'b1);
    check("t6_rd_err", bus.RD_ERR, 0);
    wr_frame(14'h0061, 16'hF00D, 32, 6, 1'b0, 1'b1);
    wait_clk(4);

    check("wr_queue_left", exp_wr.size(), 0);
    check("rd_queue_left", exp_ra.size(), 0);
    check("wr_spurious", spur_wr, 0);
    check("rd_spurious", spur_rd, 0);
    check("wr_total", n_wr_seen, n_wr_push);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
